// File: rtl/gcd.sv
// Multi-cycle unsigned GCD engine using Stein's binary algorithm.
// One operand pair is accepted per start handshake; the result is announced by a one-cycle valid pulse.
module gcd #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] result_q, result_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d = a_i;
                    b_d = b_i;
                    k_d = '0;
                    // A zero operand short-circuits: gcd(0,x)=x, including gcd(0,0)=0.
                    if (a_i == '0) begin
                        result_d = b_i;
                        state_d  = DONE;
                    end else if (b_i == '0) begin
                        result_d = a_i;
                        state_d  = DONE;
                    end else begin
                        state_d = REDUCE;
                    end
                end
            end

            REDUCE: begin
                if (a_q == b_q) begin
                    result_d = a_q << k_q;
                    state_d  = DONE;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + KW'(1);
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    // Difference of two odd values is even, so the shift is exact.
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o   = (state_q != IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_gcd.sv
// Self-checking bench for gcd: directed table, multi-cycle corner sequences and
// randomized operands compared against a Euclid-based reference model.
module tb_gcd;

    localparam int W   = 32;
    localparam int MAXLAT = 2 * W + 1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         valid;
    logic [W-1:0] result;

    int total = 0;
    int bad   = 0;

    gcd #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .start_i (start),
        .a_i     (a_in),
        .b_i     (b_in),
        .busy_o  (busy),
        .valid_o (valid),
        .result_o(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] p, q, t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one start pulse and wait (bounded) for the valid pulse.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output int lat,
                       output bit got, output bit busy_ok);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start   = 1'b0;
        got     = 1'b0;
        busy_ok = 1'b1;
        res     = '0;
        lat     = 1;
        while (!got && lat <= MAXLAT + 4) begin
            if (!busy) busy_ok = 1'b0;
            if (valid) begin
                got = 1'b1;
                res = result;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        // Valid must be a single-cycle pulse.
        @(posedge clk);
        #1;
        chk("valid_single_pulse", {31'd0, valid}, 32'd0);
    endtask

    task automatic check_pair(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] exp);
        logic [W-1:0] res;
        int lat;
        bit got, bok;
        run(a, b, res, lat, got, bok);
        chk({tag, "_valid_seen"}, {31'd0, got}, 32'd1);
        chk({tag, "_result"}, res, exp);
        chk({tag, "_busy"}, {31'd0, bok}, 32'd1);
        if (a == 0 || b == 0)
            chk({tag, "_latency"}, lat, 1);
        else
            chk({tag, "_latency_bound"}, {31'd0, (lat <= MAXLAT)}, 32'd1);
        $display("txn %s a=0x%0h b=0x%0h result=0x%0h exp=0x%0h latency=%0d", tag, a, b, res, exp, lat);
    endtask

    vec_t vecs[11];

    initial begin
        int vcount;
        int lat;
        logic [W-1:0] ra, rb, rexp, held;
        bit hold_ok;

        vecs[0]  = '{a: 32'd48,         b: 32'd18,         exp: 32'd6};
        vecs[1]  = '{a: 32'd1071,       b: 32'd462,        exp: 32'd21};
        vecs[2]  = '{a: 32'd0,          b: 32'd7,          exp: 32'd7};
        vecs[3]  = '{a: 32'd9,          b: 32'd0,          exp: 32'd9};
        vecs[4]  = '{a: 32'd0,          b: 32'd0,          exp: 32'd0};
        vecs[5]  = '{a: 32'd17,         b: 32'd17,         exp: 32'd17};
        vecs[6]  = '{a: 32'd13,         b: 32'd8,          exp: 32'd1};
        vecs[7]  = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFE,   exp: 32'd1};
        vecs[8]  = '{a: 32'd1024,       b: 32'd96,         exp: 32'd32};
        vecs[9]  = '{a: 32'h80000000,   b: 32'h80000000,   exp: 32'h80000000};
        vecs[10] = '{a: 32'h80000000,   b: 32'd6,          exp: 32'd2};

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_valid", {31'd0, valid}, 32'd0);
        chk("post_rst_result", result, 32'd0);

        for (int i = 0; i < 11; i++)
            check_pair($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);

        // Reset in the middle of a reduction aborts it with no valid pulse.
        @(negedge clk);
        start = 1'b1;
        a_in  = 32'd48;
        b_in  = 32'd18;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("midrst_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (valid) vcount++;
        end
        chk("midrst_no_valid", vcount, 0);
        $display("txn midreset a=48 b=18 valid_pulses_after=%0d", vcount);

        // Start held for two edges; operands changed on the second edge must be ignored.
        @(negedge clk);
        start = 1'b1;
        a_in  = 32'd12;
        b_in  = 32'd18;
        @(negedge clk);
        a_in  = 32'd10;
        b_in  = 32'd4;
        @(negedge clk);
        start = 1'b0;
        vcount = 0;
        held   = '0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                vcount++;
                held = result;
            end
        end
        chk("held_start_pulses", vcount, 1);
        chk("held_start_result", held, 32'd6);
        $display("txn heldstart a=12 b=18 result=0x%0h pulses=%0d", held, vcount);

        // Back-to-back: the previous result must hold until the next valid.
        @(negedge clk);
        start = 1'b1;
        a_in  = 32'd1071;
        b_in  = 32'd462;
        @(negedge clk);
        start   = 1'b0;
        hold_ok = 1'b1;
        lat     = 0;
        while (!valid && lat < MAXLAT + 4) begin
            if (result !== 32'd6) hold_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_result_hold", {31'd0, hold_ok}, 32'd1);
        chk("b2b_result", result, 32'd21);
        $display("txn backtoback a=1071 b=462 result=0x%0h", result);
        @(negedge clk);

        // Randomized operands, some sharing a power-of-two factor.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom();
            rb = $urandom();
            if (i % 4 == 1) begin
                ra = ra >> $urandom_range(0, 31);
                rb = rb >> $urandom_range(0, 31);
            end
            if (i % 4 == 2) begin
                int sh;
                sh = $urandom_range(0, 20);
                ra = (ra >> 20) << sh;
                rb = (rb >> 20) << sh;
            end
            if (i % 10 == 3) ra = '0;
            rexp = ref_gcd(ra, rb);
            check_pair($sformatf("rnd%0d", i), ra, rb, rexp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
